// File: rtl/instr_memory.sv
`default_nettype none
// ============================================================================
//  Module   : instr_memory
//  Brief    : Word-addressed instruction memory for the RV32i fetch stage.
//             Combinational read at PC_Out, sequential load port, sticky
//             address-fault reporting.
//  Revision : 1.0 - initial release
// ============================================================================
module instr_memory #(
    parameter int    DEPTH     = 256,
    parameter int    ADDR_BITS = 8,
    parameter string INIT_FILE = "program.hex"
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic [31:0]          PC_Out,
    output logic [31:0]          Instr,
    output logic                 Addr_Err,
    output logic                 Misaligned,
    output logic                 Fault,
    input  logic                 Load_En,
    input  logic [31:0]          Load_Data,
    output logic [ADDR_BITS-1:0] Load_Ptr,
    output logic                 Load_Full
);

    // The built-in image is the content of program.hex; an empty name means a blank memory.
    localparam bit c_load_image = (INIT_FILE != "");

    localparam logic [ADDR_BITS-1:0] c_last_idx = ADDR_BITS'(DEPTH - 1);

    function automatic logic [31:0] f_init_word(input int idx);
        logic [31:0] word;
        word = 32'h0000_0000;
        if (c_load_image) begin
            case (idx)
                0:       word = 32'h0020_0093;
                1:       word = 32'h0030_0113;
                2:       word = 32'h0020_81b3;
                3:       word = 32'h0000_006f;
                default: word = 32'h0000_0000;
            endcase
        end
        return word;
    endfunction

    logic [ADDR_BITS-1:0] r_load_ptr;
    logic                 r_load_full;
    logic                 r_fault;

    logic [31:0]          w_words [DEPTH];
    logic [ADDR_BITS-1:0] w_rd_idx;
    logic                 w_addr_err;
    logic                 w_misaligned;
    logic                 w_load_fire;

    // ------------------------------------------------------------------
    // Address decode and fault detection
    // ------------------------------------------------------------------
    assign w_rd_idx     = PC_Out[ADDR_BITS+1:2];
    assign w_addr_err   = |PC_Out[31:ADDR_BITS+2];
    assign w_misaligned = |PC_Out[1:0];

    // A load edge seen while reset is held must not touch the array.
    assign w_load_fire  = Load_En & RST_N;

    // ------------------------------------------------------------------
    // Storage: one register per word, preloaded at elaboration, never reset
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
        logic [31:0] r_word = f_init_word(gi);

        always_ff @(posedge CLK) begin
            if (w_load_fire && (r_load_ptr == ADDR_BITS'(gi))) begin
                r_word <= Load_Data;
            end
        end

        assign w_words[gi] = r_word;
    end

    // ------------------------------------------------------------------
    // Load pointer and wrap flag
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_load_ptr  <= '0;
            r_load_full <= 1'b0;
        end else if (Load_En) begin
            r_load_ptr <= r_load_ptr + 1'b1;
            if (r_load_ptr == c_last_idx) begin
                r_load_full <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Sticky fault, cleared only by reset
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_fault <= 1'b0;
        end else begin
            r_fault <= r_fault | w_addr_err | w_misaligned;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign Instr      = w_addr_err ? 32'h0000_0000 : w_words[w_rd_idx];
    assign Addr_Err   = w_addr_err;
    assign Misaligned = w_misaligned;
    assign Fault      = r_fault;
    assign Load_Ptr   = r_load_ptr;
    assign Load_Full  = r_load_full;

endmodule
`default_nettype wire

// File: tb/tb_instr_memory.sv
`default_nettype none
// ============================================================================
//  Module   : tb_instr_memory
//  Brief    : Scoreboard bench for instr_memory; expectations come from a
//             reference memory model kept in the bench.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_instr_memory;

    localparam int DEPTH     = 256;
    localparam int ADDR_BITS = 8;

    localparam int c_sig_instr = 0;
    localparam int c_sig_aerr  = 1;
    localparam int c_sig_mis   = 2;
    localparam int c_sig_fault = 3;
    localparam int c_sig_ptr   = 4;
    localparam int c_sig_full  = 5;

    logic                 CLK;
    logic                 RST_N;
    logic [31:0]          PC_Out;
    logic [31:0]          Instr;
    logic                 Addr_Err;
    logic                 Misaligned;
    logic                 Fault;
    logic                 Load_En;
    logic [31:0]          Load_Data;
    logic [ADDR_BITS-1:0] Load_Ptr;
    logic                 Load_Full;

    instr_memory #(
        .DEPTH     (DEPTH),
        .ADDR_BITS (ADDR_BITS),
        .INIT_FILE ("program.hex")
    ) u_dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .PC_Out     (PC_Out),
        .Instr      (Instr),
        .Addr_Err   (Addr_Err),
        .Misaligned (Misaligned),
        .Fault      (Fault),
        .Load_En    (Load_En),
        .Load_Data  (Load_Data),
        .Load_Ptr   (Load_Ptr),
        .Load_Full  (Load_Full)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        string       tag;
        int          sig;
        logic [31:0] exp;
    } sb_item_t;

    sb_item_t    r_sb_q [$];
    int          n_checks;
    int          n_errors;

    logic [31:0] m_mem [DEPTH];
    logic [7:0]  m_ptr;
    logic        m_full;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] observe(input int sig);
        logic [31:0] v;
        v = 32'h0;
        case (sig)
            c_sig_instr: v = Instr;
            c_sig_aerr:  v = {31'h0, Addr_Err};
            c_sig_mis:   v = {31'h0, Misaligned};
            c_sig_fault: v = {31'h0, Fault};
            c_sig_ptr:   v = {24'h0, Load_Ptr};
            c_sig_full:  v = {31'h0, Load_Full};
            default:     v = 32'hdead_beef;
        endcase
        return v;
    endfunction

    task automatic expect_sig(input string tag, input int sig, input logic [31:0] exp);
        sb_item_t it;
        it.tag = tag;
        it.sig = sig;
        it.exp = exp;
        r_sb_q.push_back(it);
    endtask

    // Compare every pending expectation against the settled DUT outputs.
    task automatic drain();
        sb_item_t it;
        #1;
        while (r_sb_q.size() > 0) begin
            it = r_sb_q.pop_front();
            check(it.tag, observe(it.sig), it.exp);
        end
    endtask

    task automatic expect_read(input string tag, input logic [31:0] pc);
        PC_Out = pc;
        expect_sig(tag, c_sig_instr, m_mem[pc[ADDR_BITS+1:2]]);
    endtask

    task automatic expect_load_state(input string tag);
        expect_sig({tag, "_ptr"},  c_sig_ptr,  {24'h0, m_ptr});
        expect_sig({tag, "_full"}, c_sig_full, {31'h0, m_full});
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic model_reset();
        m_ptr  = 8'h0;
        m_full = 1'b0;
    endtask

    task automatic do_load(input logic [31:0] data);
        Load_En   = 1'b1;
        Load_Data = data;
        tick();
        if (RST_N) begin
            m_mem[m_ptr] = data;
            if (m_ptr == 8'hFF) m_full = 1'b1;
            m_ptr = m_ptr + 8'h1;
        end
        Load_En = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'h0;
        m_mem[0] = 32'h0020_0093;
        m_mem[1] = 32'h0030_0113;
        m_mem[2] = 32'h0020_81b3;
        m_mem[3] = 32'h0000_006f;
        model_reset();

        RST_N     = 1'b0;
        PC_Out    = 32'h0;
        Load_En   = 1'b0;
        Load_Data = 32'h0;
        #2;
        expect_sig("rst_fault", c_sig_fault, 32'h0);
        expect_load_state("rst");
        drain();
        tick();
        RST_N = 1'b1;
        tick();

        // Default image sweep, one PC step per clock
        for (int i = 0; i < 50; i++) begin
            expect_read($sformatf("sweep_pc%0h", i * 4), i * 4);
            expect_sig("sweep_aerr",  c_sig_aerr,  32'h0);
            expect_sig("sweep_mis",   c_sig_mis,   32'h0);
            expect_sig("sweep_fault", c_sig_fault, 32'h0);
            drain();
            tick();
        end

        // Out-of-range PCs
        PC_Out = 32'h0000_0400;
        expect_sig("oor400_instr", c_sig_instr, 32'h0);
        expect_sig("oor400_aerr",  c_sig_aerr,  32'h1);
        expect_sig("oor400_fault_pre", c_sig_fault, 32'h0);
        drain();
        tick();
        expect_sig("oor400_fault", c_sig_fault, 32'h1);
        PC_Out = 32'hFFFF_FFFC;
        expect_sig("oorfffc_instr", c_sig_instr, 32'h0);
        expect_sig("oorfffc_aerr",  c_sig_aerr,  32'h1);
        drain();
        tick();
        expect_read("back0_instr", 32'h0);
        expect_sig("back0_aerr",  c_sig_aerr,  32'h0);
        expect_sig("back0_fault", c_sig_fault, 32'h1);
        drain();
        tick();
        expect_sig("sticky_fault", c_sig_fault, 32'h1);
        drain();

        // Misaligned PC, then asynchronous clear of Fault
        RST_N = 1'b0;
        #1;
        expect_sig("clr_fault", c_sig_fault, 32'h0);
        drain();
        RST_N = 1'b1;
        tick();
        PC_Out = 32'h0000_0005;
        expect_sig("mis5_instr", c_sig_instr, 32'h0030_0113);
        expect_sig("mis5_mis",   c_sig_mis,   32'h1);
        expect_sig("mis5_aerr",  c_sig_aerr,  32'h0);
        drain();
        tick();
        expect_sig("mis5_fault", c_sig_fault, 32'h1);
        drain();
        RST_N = 1'b0;
        #1;
        expect_sig("async_clr_fault", c_sig_fault, 32'h0);
        drain();
        tick();
        expect_sig("held_rst_fault", c_sig_fault, 32'h0);
        drain();
        PC_Out = 32'h0;
        #1;
        RST_N = 1'b1;
        model_reset();
        tick();

        // Three loads, with no-bypass check before each edge
        for (int k = 0; k < 3; k++) begin
            expect_read($sformatf("nobypass_w%0d", k), k * 4);
            drain();
            do_load(32'h1111_1111 * (k + 1));
        end
        expect_load_state("load3");
        drain();
        for (int k = 0; k < 4; k++) begin
            expect_read($sformatf("load3_w%0d", k), k * 4);
            drain();
        end

        // Reset in the middle of a load sequence
        RST_N = 1'b0;
        #1;
        model_reset();
        RST_N = 1'b1;
        tick();
        do_load(32'hAAAA_0000);
        do_load(32'hAAAA_0001);
        expect_load_state("mid2");
        drain();
        RST_N = 1'b0;
        #1;
        model_reset();
        expect_load_state("midrst");
        drain();
        do_load(32'hDEAD_DEAD);
        expect_load_state("rst_load_ignored");
        expect_read("rst_keep_w0", 32'h0);
        drain();
        expect_read("rst_keep_w1", 32'h4);
        drain();
        RST_N = 1'b1;
        tick();
        do_load(32'hBBBB_0000);
        expect_read("reload_w0", 32'h0);
        drain();
        expect_read("reload_w1", 32'h4);
        expect_load_state("reload");
        drain();

        // Full-depth load and wrap
        RST_N = 1'b0;
        #1;
        model_reset();
        RST_N = 1'b1;
        tick();
        for (int i = 0; i < DEPTH - 1; i++) do_load(32'h5000_0000 + i);
        expect_load_state("pre_wrap");
        drain();
        do_load(32'h5000_00FF);
        expect_load_state("wrap");
        drain();
        do_load(32'hC0FF_EE00);
        expect_load_state("post_wrap");
        expect_read("wrap_w0", 32'h0);
        drain();
        expect_read("wrap_w1", 32'h4);
        drain();
        expect_read("wrap_w255", 32'h3FC);
        drain();
        expect_read("wrap_w128", 32'h200);
        drain();

        if (r_sb_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL sb_leftover: got %0d expected 0", r_sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
